// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame parallel-to-serial path.
package fft_pkg;

  localparam int NUM_WORDS = 48;
  localparam int WORD_W    = 16;
  localparam int IDX_W     = 6;

  // Index of the final word of a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_e;

endpackage

// File: rtl/pts_shift_reg.sv
// 48-word frame buffer: parallel load, shifts one word toward index 0 per
// enable, so the word currently being presented is always at index 0.
module pts_shift_reg
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  frame_t            data_i,
  output logic [WORD_W-1:0] word_o
);

  frame_t buf_q;

  // Load takes priority; a shift fills the top slot with zero so a drained
  // buffer holds no stale frame data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_q <= '0;
    end else if (load_i) begin
      buf_q <= data_i;
    end else if (shift_i) begin
      buf_q <= {WORD_W'(0), buf_q[NUM_WORDS-1:1]};
    end
  end

  assign word_o = buf_q[0];

endmodule

// File: rtl/pts_wrapper.sv
// Parallel-to-serial wrapper: captures a 48-word FFT frame and hands it out
// one word per consumer strobe, pulsing done after the last word is taken.
module pts_wrapper
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  frame_t            data_par,
  input  logic              shift_strobe,
  output logic [WORD_W-1:0] serial_out,
  output logic              serial_valid,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  word_idx
);

  pts_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              buf_load;
  logic              buf_shift;
  logic [WORD_W-1:0] buf_word;

  pts_shift_reg u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (buf_load),
    .shift_i (buf_shift),
    .data_i  (data_par),
    .word_o  (buf_word)
  );

  // State, word counter and done pulse registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; load is only looked at in IDLE, so a load during a
  // frame (even alongside the final strobe) cannot disturb the buffer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    buf_load  = 1'b0;
    buf_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          buf_load = 1'b1;
          idx_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_strobe) begin
          buf_shift = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy         = (state_q == SHIFT);
  assign serial_valid = busy;
  assign serial_out   = busy ? buf_word : '0;
  assign word_idx     = idx_q;
  assign done         = done_q;

endmodule
